// File: rtl/fp754_pkg.sv
// Shared IEEE-754 single-precision field widths, flag positions, FSM states and operand classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp754_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int INVALID = 3;
    localparam int OVF     = 2;
    localparam int UNF     = 1;
    localparam int INEXACT = 0;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORMAL
    } fp_class_t;

    // Exponent 0 counts as zero, so subnormal operands flush.
    function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] exponent,
                                              input logic [MAN_W-1:0] mantissa);
        if (exponent == '0)
            return CLS_ZERO;
        if (exponent == '1)
            return (mantissa == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even of a normalised product, then overflow/underflow pack.
// Latency: combinational.
// Backpressure: none; the caller registers the output.
module fp_round_pack
    import fp754_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [45:0]       frac,
    output logic [31:0]       result,
    output logic [3:0]        flags
);

    logic [MAN_W-1:0] mant;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   mant_inc;
    logic signed [9:0] exp_r;

    always_comb begin
        mant     = frac[45:23];
        guard    = frac[22];
        sticky   = |frac[21:0];
        round_up = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        // A carry out leaves the low field at zero and bumps the exponent.
        exp_r    = exponent + {9'd0, mant_inc[MAN_W]};

        result          = {sign, exp_r[7:0], mant_inc[MAN_W-1:0]};
        flags           = '0;
        flags[INEXACT]  = guard | sticky;

        if (exp_r >= 10'sd255) begin
            result         = {sign, 8'hFF, 23'h0};
            flags[OVF]     = 1'b1;
            flags[INEXACT] = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            result         = {sign, 31'h0};
            flags[UNF]     = 1'b1;
            flags[INEXACT] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add mantissa product, normalise, RNE round, pack.
// Latency: 24/BITS_PER_CYCLE+2 clocks for normal operands; special operands report right after accept.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_mul_seq
    import fp754_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exponent,
    input  logic [MAN_W-1:0]  a_mantissa,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exponent,
    input  logic [MAN_W-1:0]  b_mantissa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic [3:0]        flags
);

    localparam int ITERS = 24 / BITS_PER_CYCLE;
    localparam int CNT_W = 5;

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 6 || BITS_PER_CYCLE == 8 ||
          BITS_PER_CYCLE == 12 || BITS_PER_CYCLE == 24)) begin : g_bad_bits_per_cycle
        $error("fp_mul_seq: BITS_PER_CYCLE must be one of 1,2,3,4,6,8,12,24");
    end

    state_t            state;
    state_t            state_nxt;
    logic [47:0]       acc;
    logic [47:0]       mcand;
    logic [23:0]       mplier;
    logic [CNT_W-1:0]  iter;
    logic signed [9:0] exp_q;
    logic              sign_q;
    logic [31:0]       result_q;
    logic [3:0]        flags_q;
    logic              out_valid_q;

    fp_class_t         a_cls;
    fp_class_t         b_cls;
    logic              sign_in;
    logic              special;
    logic [31:0]       spec_result;
    logic [3:0]        spec_flags;
    logic [47:0]       partial;
    logic              last_iter;
    logic [31:0]       rp_result;
    logic [3:0]        rp_flags;

    always_comb begin
        a_cls       = fp_classify(a_exponent, a_mantissa);
        b_cls       = fp_classify(b_exponent, b_mantissa);
        sign_in     = a_sign ^ b_sign;
        special     = (a_cls != CLS_NORMAL) || (b_cls != CLS_NORMAL);
        spec_result = {sign_in, 31'h0};
        spec_flags  = '0;
        if (a_cls == CLS_NAN || b_cls == CLS_NAN ||
            (a_cls == CLS_INF && b_cls == CLS_ZERO) ||
            (a_cls == CLS_ZERO && b_cls == CLS_INF)) begin
            spec_result         = QNAN;
            spec_flags[INVALID] = 1'b1;
        end else if (a_cls == CLS_INF || b_cls == CLS_INF) begin
            spec_result = {sign_in, 8'hFF, 23'h0};
        end
    end

    // Sum of this cycle's partial products; mcand is pre-shifted to the current weight.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j])
                partial = partial + (mcand << j);
        end
    end

    assign last_iter = (iter == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : MUL;
            MUL:     if (last_iter) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            iter        <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sign_in;
                        exp_q  <= $signed({2'b00, a_exponent}) + $signed({2'b00, b_exponent})
                                  - 10'(BIAS);
                        mcand  <= {24'd0, 1'b1, a_mantissa};
                        mplier <= {1'b1, b_mantissa};
                        acc    <= '0;
                        iter   <= '0;
                        if (special) begin
                            result_q    <= spec_result;
                            flags_q     <= spec_flags;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    iter   <= iter + 1'b1;
                end
                NORM: begin
                    // Bit shifted out lands in bit 0, which only ever feeds sticky.
                    if (acc[47]) begin
                        acc   <= {1'b0, acc[47:2], acc[1] | acc[0]};
                        exp_q <= exp_q + 10'sd1;
                    end
                end
                ROUND: begin
                    result_q    <= rp_result;
                    flags_q     <= rp_flags;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fp_round_pack u_round_pack (
        .sign     (sign_q),
        .exponent (exp_q),
        .frac     (acc[45:0]),
        .result   (rp_result),
        .flags    (rp_flags)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
